// File: rtl/uart_led_ctrl.sv
// uart_led_ctrl: decodes UART command bytes into value/mode/brightness and drives
// registered, PWM-dimmed LED outputs in binary, bar-graph, blink or off display modes.
module uart_led_ctrl #(
  parameter int NUM_LEDS  = 4,
  parameter int BLINK_DIV = 25_000_000,
  parameter int PWM_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_LEDS-1:0] leds_out,
  output logic [1:0]          mode_out,
  output logic                cmd_err
);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  typedef enum logic [1:0] {BINARY, BAR, BLINK, OFF} mode_e;
  mode_e                mode_q, mode_d;
  logic [5:0]           value_q, value_d;
  logic [PWM_BITS-1:0]  bright_q, bright_d, pwm_cnt_q, pwm_cnt_d;
  logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d, blink_wrap;
  logic                 cmd_err_q, cmd_err_d, pwm_on;
  logic [NUM_LEDS-1:0]  leds_q, leds_d, bar, pattern;
  always_comb begin
    value_d       = value_q;
    mode_d        = mode_q;
    bright_d      = bright_q;
    cmd_err_d     = 1'b0;
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    blink_wrap    = blink_cnt_q == BLINK_MAX;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    if (rx_valid) begin
      case (rx_data[7:6])
        2'b00: value_d = rx_data[5:0];
        2'b01: begin
          mode_d        = mode_e'(rx_data[1:0]);
          blink_cnt_d   = '0;
          blink_phase_d = 1'b1;
        end
        2'b10: bright_d = rx_data[PWM_BITS-1:0];
        default: cmd_err_d = 1'b1;
      endcase
    end
    bar = '0;
    for (int i = 0; i < NUM_LEDS; i++) bar[i] = value_q > 6'(i);
    pattern = mode_q == BINARY                  ? value_q[NUM_LEDS-1:0] :
              mode_q == BAR                     ? bar :
              (mode_q == BLINK && blink_phase_q) ? value_q[NUM_LEDS-1:0] : '0;
    // full brightness must be solid on, which the compare alone cannot give
    pwm_on = (&bright_q) | (pwm_cnt_q < bright_q);
    leds_d = pwm_on ? pattern : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= BINARY;
      value_q       <= '0;
      bright_q      <= '1;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      cmd_err_q     <= 1'b0;
      leds_q        <= '0;
    end else begin
      mode_q        <= mode_d;
      value_q       <= value_d;
      bright_q      <= bright_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      cmd_err_q     <= cmd_err_d;
      leds_q        <= leds_d;
    end
  end
  assign leds_out = leds_q;
  assign mode_out = mode_q;
  assign cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_uart_led_ctrl.sv
// tb_uart_led_ctrl: directed command bytes with hand-computed expectations queued per
// cycle; a monitor compares {leds_out, mode_out, cmd_err} when each entry comes due.
module tb_uart_led_ctrl;
  logic       clk = 1'b0, rst_n, rx_valid;
  logic [7:0] rx_data;
  logic [3:0] leds_out;
  logic [1:0] mode_out;
  logic       cmd_err;
  int cyc = 0, nvec = 0, nerr = 0, r = 0;
  typedef struct {int cyc; logic [6:0] v;} exp_t;
  exp_t       q[$];
  logic [6:0] rq[$];
  uart_led_ctrl #(.NUM_LEDS(4), .BLINK_DIV(4), .PWM_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .leds_out(leds_out), .mode_out(mode_out), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void exp_at(int c, logic [3:0] l, logic [1:0] m, logic e);
    q.push_back('{c, {l, m, e}});
  endfunction
  function automatic void check(string nm, logic [6:0] act, logic [6:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: leds/mode/err got %b_%b_%b, expected %b_%b_%b", nm,
               act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
    end
  endfunction
  function automatic bit pwm_on(int br, int c);
    return br == 15 || ((c - 1 - r) % 16) < br;
  endfunction
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc == cyc) begin
        check($sformatf("cycle_%0d", cyc), {leds_out, mode_out, cmd_err}, q[i].v);
        q.delete(i);
      end else i++;
    end
  end
  always @(negedge rst_n) begin
    #1;
    if (rq.size() > 0) check("async_reset", {leds_out, mode_out, cmd_err}, rq.pop_front());
  end
  task automatic send(input logic [7:0] b, input logic [3:0] cur, input logic [3:0] nxt,
                      input logic [1:0] m, input logic e);
    @(negedge clk);
    exp_at(cyc + 1, cur, m, e);
    exp_at(cyc + 2, nxt, m, 1'b0);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic pwm_seq(input int b, input int prev);
    @(negedge clk);
    for (int c = cyc + 1; c <= cyc + 32; c++)
      exp_at(c, pwm_on(c == cyc + 1 ? prev : b, c) ? 4'hF : 4'h0, 2'd0, 1'b0);
    rx_data = 8'h80 | 8'(b);
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (31) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #2;
    rq.push_back(7'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    exp_at(cyc + 1, 4'b0000, 2'd0, 1'b0);
    send(8'h05, 4'b0000, 4'b0101, 2'd0, 1'b0);
    send(8'h3A, 4'b0101, 4'b1010, 2'd0, 1'b0);
    send(8'h41, 4'b1010, 4'b1111, 2'd1, 1'b0);
    send(8'h03, 4'b1111, 4'b0111, 2'd1, 1'b0);
    send(8'h09, 4'b0111, 4'b1111, 2'd1, 1'b0);
    send(8'h00, 4'b1111, 4'b0000, 2'd1, 1'b0);
    send(8'h02, 4'b0000, 4'b0011, 2'd1, 1'b0);
    send(8'hC3, 4'b0011, 4'b0011, 2'd1, 1'b1);
    send(8'h40, 4'b0011, 4'b0010, 2'd0, 1'b0);
    send(8'h0F, 4'b0010, 4'b1111, 2'd0, 1'b0);
    @(negedge clk);
    exp_at(cyc + 1, 4'b1111, 2'd0, 1'b0);
    exp_at(cyc + 2, 4'b0001, 2'd0, 1'b0);
    exp_at(cyc + 3, 4'b0010, 2'd0, 1'b0);
    rx_data = 8'h01;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'h02;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    send(8'h0F, 4'b0010, 4'b1111, 2'd0, 1'b0);
    @(negedge clk);
    exp_at(cyc + 1, 4'b1111, 2'd2, 1'b0);
    for (int i = 2; i <= 17; i++)
      exp_at(cyc + i, (((i - 2) / 4) % 2 == 0) ? 4'b1111 : 4'b0000, 2'd2, 1'b0);
    rx_data = 8'h42;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (16) @(negedge clk);
    send(8'h43, 4'b1111, 4'b0000, 2'd3, 1'b0);
    send(8'h40, 4'b0000, 4'b1111, 2'd0, 1'b0);
    pwm_seq(4, 15);
    pwm_seq(0, 4);
    pwm_seq(15, 0);
    send(8'h41, 4'b1111, 4'b1111, 2'd1, 1'b0);
    @(negedge clk);
    exp_at(cyc + 1, 4'b1111, 2'd1, 1'b1);
    rx_data = 8'hC3;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #2;
    rq.push_back(7'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_at(cyc + 1, 4'b0000, 2'd0, 1'b0);
    send(8'h05, 4'b0000, 4'b0101, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    if (q.size() != 0 || rq.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL leftover: %0d scheduled and %0d reset checks never compared, expected 0",
               q.size(), rq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
